// File: rtl/serdes_pkg.sv
// Shared types and helpers for the piso_reg / SIPO_reg serial link.
// Parity framing is enabled in piso_reg by defining PISO_PARITY_EN.
package serdes_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } piso_state_t;

  localparam int DEFAULT_DATA_WIDTH = 8;

  // Counter must reach DATA_WIDTH itself, hence the +1.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// One-entry holding register in front of the PISO shifter.
// Ready depends only on the full flag and reset, never on din_valid_i.
module piso_hold_buf
  import serdes_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [DATA_WIDTH-1:0] din_bus_i,
  input  logic                  din_valid_i,
  output logic                  din_ready_o,
  input  logic                  take_i,
  output logic [DATA_WIDTH-1:0] hold_word_o,
  output logic                  hold_full_o
);

  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  full_q, full_d;
  logic                  accept;

  // Handshake: a word transfers on a rising edge where din_valid_i && din_ready_o.
  assign din_ready_o = !full_q && !reset_i;
  assign accept      = din_valid_i && din_ready_o;

  // accept needs an empty buffer and take_i a full one, so they never coincide.
  always_comb begin
    hold_d = hold_q;
    full_d = full_q;
    if (accept) begin
      hold_d = din_bus_i;
      full_d = 1'b1;
    end else if (take_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hold_q <= '0;
      full_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      full_q <= full_d;
    end
  end

  assign hold_word_o = hold_q;
  assign hold_full_o = full_q;

endmodule

// File: rtl/piso_reg.sv
// Parallel-in serial-out register feeding SIPO_reg; one bit per clock framed by wr_en_o.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_reg
  import serdes_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [DATA_WIDTH-1:0] din_bus_i,
  input  logic                  din_valid_i,
  output logic                  din_ready_o,
  output logic                  serial_data_o,
  output logic                  wr_en_o,
  output logic                  busy_o
);

  localparam int CW = cnt_width(DATA_WIDTH);
  localparam int IW = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] hold_word;
  logic                  hold_full;
  logic                  take;

  piso_state_t           state_q;
  logic [CW-1:0]         bit_cnt_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  serial_q;
  logic                  wr_en_q;

  logic                  last_bit;
  logic [IW-1:0]         bit_idx;

  piso_hold_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_hold_buf (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .din_bus_i   (din_bus_i),
    .din_valid_i (din_valid_i),
    .din_ready_o (din_ready_o),
    .take_i      (take),
    .hold_word_o (hold_word),
    .hold_full_o (hold_full)
  );

  // shift_q is indexed, not shifted, so the parity bit can still see the whole word.
  assign last_bit = (bit_cnt_q == CW'(DATA_WIDTH - 1));
  assign bit_idx  = MSB_FIRST ? (IW'(DATA_WIDTH - 1) - IW'(bit_cnt_q)) : IW'(bit_cnt_q);

  // Points where the shifter can swallow the held word without leaving a gap.
  always_comb begin
    take = 1'b0;
    case (state_q)
      IDLE:   take = hold_full;
`ifdef PISO_PARITY_EN
      SHIFT:  take = 1'b0;
      PARITY: take = hold_full;
`else
      SHIFT:  take = hold_full && last_bit;
`endif
      default: take = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      serial_q  <= 1'b0;
      wr_en_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          wr_en_q <= 1'b0;
        end
        SHIFT: begin
          serial_q  <= shift_q[bit_idx];
          wr_en_q   <= 1'b1;
          bit_cnt_q <= bit_cnt_q + CW'(1);
          if (last_bit) begin
`ifdef PISO_PARITY_EN
            state_q <= PARITY;
`else
            state_q <= IDLE;
`endif
          end
        end
`ifdef PISO_PARITY_EN
        PARITY: begin
          serial_q <= ^shift_q;
          wr_en_q  <= 1'b1;
          state_q  <= IDLE;
        end
`endif
        default: begin
          state_q <= IDLE;
          wr_en_q <= 1'b0;
        end
      endcase
      // A reload overrides the IDLE decision above; the bit driven this edge still comes from the old word.
      if (take) begin
        shift_q   <= hold_word;
        bit_cnt_q <= '0;
        state_q   <= SHIFT;
      end
    end
  end

  assign serial_data_o = serial_q;
  assign wr_en_o       = wr_en_q;
  assign busy_o        = (state_q != IDLE) || hold_full || wr_en_q;

endmodule

// File: tb/tb_piso_reg.sv
// Scoreboarded bench for piso_reg: an MSB-first and an LSB-first instance share one stimulus stream.
// Honours PISO_PARITY_EN when the design is built with it.
module tb_piso_reg;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic         clk_i = 1'b0;
  logic         reset_i = 1'b1;
  logic [W-1:0] din_bus_i = '0;
  logic         din_valid_i = 1'b0;

  logic m_ready, m_serial, m_wr_en, m_busy;
  logic l_ready, l_serial, l_wr_en, l_busy;

  int   checks = 0;
  int   failures = 0;
  int   bits_m = 0;
  logic exp_m_q[$];
  logic exp_l_q[$];
  logic e_m, e_l;

  piso_reg #(.DATA_WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .din_bus_i     (din_bus_i),
    .din_valid_i   (din_valid_i),
    .din_ready_o   (m_ready),
    .serial_data_o (m_serial),
    .wr_en_o       (m_wr_en),
    .busy_o        (m_busy)
  );

  piso_reg #(.DATA_WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .din_bus_i     (din_bus_i),
    .din_valid_i   (din_valid_i),
    .din_ready_o   (l_ready),
    .serial_data_o (l_serial),
    .wr_en_o       (l_wr_en),
    .busy_o        (l_busy)
  );

  // Clock / watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the serial order of a word, plus its even parity when enabled.
  function automatic void push_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      exp_m_q.push_back(w[W-1-i]);
      exp_l_q.push_back(w[i]);
    end
`ifdef PISO_PARITY_EN
    exp_m_q.push_back(^w);
    exp_l_q.push_back(^w);
`endif
  endfunction

  // Monitor: every framed bit must match the next expected bit.
  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (m_wr_en) begin
        bits_m++;
        if (exp_m_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL msb_bit: got unexpected bit %b expected none at %0t", m_serial, $time);
        end else begin
          e_m = exp_m_q.pop_front();
          check_bit("msb_bit", m_serial, e_m);
        end
      end
      if (l_wr_en) begin
        if (exp_l_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL lsb_bit: got unexpected bit %b expected none at %0t", l_serial, $time);
        end else begin
          e_l = exp_l_q.pop_front();
          check_bit("lsb_bit", l_serial, e_l);
        end
      end
    end
  end

  // Driver: called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [W-1:0] w);
    int waited;
    waited = 0;
    din_bus_i   = w;
    din_valid_i = 1'b1;
    @(negedge clk_i);
    while (!m_ready && waited < 100) begin
      @(negedge clk_i);
      waited++;
    end
    if (!m_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got ready=0 expected ready=1 within 100 cycles");
      din_valid_i = 1'b0;
    end else begin
      check_bit("ready_match", l_ready, m_ready);
      push_word(w);
      @(posedge clk_i);
      #1;
      din_valid_i = 1'b0;
      din_bus_i   = W'($urandom);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk_i);
    while ((m_busy || l_busy || m_wr_en) && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    check_bit("drain_idle", m_busy || l_busy, 1'b0);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int lat, run, seen, start;

    // Reset state
    reset_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_bit("reset_ready", m_ready, 1'b0);
    check_bit("reset_wr_en", m_wr_en || l_wr_en, 1'b0);
    check_bit("reset_busy", m_busy || l_busy, 1'b0);
    check_bit("reset_serial", m_serial || l_serial, 1'b0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    @(negedge clk_i);
    check_bit("ready_after_reset", m_ready, 1'b1);

    // Single word: latency, bit order, frame length, return to idle
    @(posedge clk_i);
    #1;
    send(8'hA5);
    lat = 0;
    do begin
      @(posedge clk_i);
      lat++;
      @(negedge clk_i);
    end while (!m_wr_en && lat < 10);
    check_int("first_bit_latency", lat, 2);
    run = 1;
    while (m_wr_en && run < 40) begin
      @(negedge clk_i);
      if (m_wr_en) run++;
    end
    check_int("single_frame_len", run, FRAME);
    check_bit("idle_busy", m_busy, 1'b0);
    check_bit("idle_wr_en", m_wr_en, 1'b0);
    @(posedge clk_i);
    #1;

    // Back-to-back frames with no gap
    send(8'hFF);
    send(8'h00);
    @(negedge clk_i);
    check_bit("ready_while_held", m_ready, 1'b0);
    check_bit("busy_while_held", m_busy, 1'b1);
    run = 0;
    while (m_wr_en && run < 40) begin
      run++;
      @(negedge clk_i);
    end
    check_int("stream_run_len", run, 2 * FRAME);
    wait_idle();

    // LSB-first instance sees bit 0 first
    send(8'h01);
    @(posedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    check_bit("lsb_first_wr_en", l_wr_en, 1'b1);
    check_bit("lsb_first_bit", l_serial, 1'b1);
    check_bit("msb_first_bit", m_serial, 1'b0);
    wait_idle();

    // Reset on the 4th bit with a word held
    send(8'hC3);
    send(8'h5A);
    start = bits_m;
    seen  = 0;
    while ((bits_m - start) < 4 && seen < 20) begin
      @(negedge clk_i);
      #1;
      seen++;
    end
    check_int("bits_before_reset", bits_m - start, 4);
    reset_i = 1'b1;
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    exp_m_q.delete();
    exp_l_q.delete();
    @(negedge clk_i);
    check_bit("abort_wr_en", m_wr_en || l_wr_en, 1'b0);
    check_bit("abort_busy", m_busy || l_busy, 1'b0);
    check_bit("abort_ready", m_ready, 1'b1);
    seen = 0;
    repeat (20) begin
      @(negedge clk_i);
      if (m_wr_en || l_wr_en) seen++;
    end
    check_int("held_word_dropped", seen, 0);
    @(posedge clk_i);
    #1;

    // Parity-sensitive pair
    send(8'h07);
    send(8'h03);
    wait_idle();

    // Random stream with random idle gaps
    for (int i = 0; i < 256; i++) begin
      repeat ($urandom_range(0, 3) == 0 ? $urandom_range(1, 12) : 0) begin
        @(posedge clk_i);
        #1;
      end
      send(W'($urandom));
    end
    wait_idle();

    check_int("exp_queue_empty", exp_m_q.size() + exp_l_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
